// File: rtl/bsg_axil_master_fsm.sv
// bsg_axil_master_fsm
// Single-outstanding AXI4-Lite initiator. Converts one valid/ready request
// into an AW+W+B write or an AR+R read, and returns the response on a
// valid/yumi interface. All outputs are registered. The one exception is
// ready_and_o, which is also gated by reset_i so that it stays low while
// reset is high.
// Optional feature: define BSG_AXIL_MASTER_TIMEOUT_EN to enable it.
//   - B and R waits time out after timeout_p cycles and return DECERR.
//   - The late response is then drained before the next request is taken.
module bsg_axil_master_fsm
  #(parameter int addr_width_p = 32
    , parameter int data_width_p = 32
    , parameter int timeout_p = 1024
  )
  (input  logic                      clk_i
   , input  logic                      reset_i

   , input  logic                      v_i
   , output logic                      ready_and_o
   , input  logic                      w_i
   , input  logic [addr_width_p-1:0]   addr_i
   , input  logic [data_width_p-1:0]   data_i
   , input  logic [data_width_p/8-1:0] wmask_i

   , output logic                      v_o
   , input  logic                      yumi_i
   , output logic                      w_o
   , output logic [data_width_p-1:0]   data_o
   , output logic [1:0]                resp_o

   , output logic [addr_width_p-1:0]   m_axil_awaddr_o
   , output logic [2:0]                m_axil_awprot_o
   , output logic                      m_axil_awvalid_o
   , input  logic                      m_axil_awready_i

   , output logic [data_width_p-1:0]   m_axil_wdata_o
   , output logic [data_width_p/8-1:0] m_axil_wstrb_o
   , output logic                      m_axil_wvalid_o
   , input  logic                      m_axil_wready_i

   , input  logic [1:0]                m_axil_bresp_i
   , input  logic                      m_axil_bvalid_i
   , output logic                      m_axil_bready_o

   , output logic [addr_width_p-1:0]   m_axil_araddr_o
   , output logic [2:0]                m_axil_arprot_o
   , output logic                      m_axil_arvalid_o
   , input  logic                      m_axil_arready_i

   , input  logic [data_width_p-1:0]   m_axil_rdata_i
   , input  logic [1:0]                m_axil_rresp_i
   , input  logic                      m_axil_rvalid_i
   , output logic                      m_axil_rready_o
  );

  // Elaboration-time parameter sanity checks
  if ((data_width_p % 8) != 0) begin : g_width_check
    $error("bsg_axil_master_fsm: data_width_p must be a multiple of 8");
  end
  if (timeout_p < 1) begin : g_timeout_check
    $error("bsg_axil_master_fsm: timeout_p must be at least 1");
  end

`ifdef BSG_AXIL_MASTER_TIMEOUT_EN
  typedef enum logic [2:0] {
    e_idle, e_waddr, e_wresp, e_raddr, e_rdata, e_resp, e_drain
  } state_e;

  localparam int timer_width_lp = $clog2(timeout_p + 1);
  localparam logic [timer_width_lp-1:0] timer_last_lp = timer_width_lp'(timeout_p - 1);

  logic [timer_width_lp-1:0] timer_reg;
  logic                      timed_out_reg;
`else
  typedef enum logic [2:0] {
    e_idle, e_waddr, e_wresp, e_raddr, e_rdata, e_resp
  } state_e;
`endif

  state_e                    state_reg;
  logic                      ready_reg;
  logic                      awvalid_reg, wvalid_reg, bready_reg;
  logic                      arvalid_reg, rready_reg;
  logic                      v_reg, w_o_reg;
  logic [addr_width_p-1:0]   addr_reg;
  logic [data_width_p-1:0]   data_reg;
  logic [data_width_p/8-1:0] wmask_reg;
  logic                      w_reg;
  logic [data_width_p-1:0]   data_o_reg;
  logic [1:0]                resp_reg;

  // Combinational completion of each write channel: the channel has already
  // handshaken, or it handshakes in this cycle.
  logic aw_done, w_done;
  assign aw_done = ~awvalid_reg | m_axil_awready_i;
  assign w_done  = ~wvalid_reg  | m_axil_wready_i;

  // Transaction sequencer: one request in flight, all outputs registered
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_reg   <= e_idle;
      ready_reg   <= 1'b1;
      awvalid_reg <= 1'b0;
      wvalid_reg  <= 1'b0;
      bready_reg  <= 1'b0;
      arvalid_reg <= 1'b0;
      rready_reg  <= 1'b0;
      v_reg       <= 1'b0;
      w_o_reg     <= 1'b0;
      addr_reg    <= '0;
      data_reg    <= '0;
      wmask_reg   <= '0;
      w_reg       <= 1'b0;
      data_o_reg  <= '0;
      resp_reg    <= 2'b00;
`ifdef BSG_AXIL_MASTER_TIMEOUT_EN
      timer_reg     <= '0;
      timed_out_reg <= 1'b0;
`endif
    end else begin
      case (state_reg)
        e_idle: begin
          if (v_i) begin
            addr_reg  <= addr_i;
            data_reg  <= data_i;
            wmask_reg <= wmask_i;
            w_reg     <= w_i;
            ready_reg <= 1'b0;
            if (w_i) begin
              state_reg   <= e_waddr;
              awvalid_reg <= 1'b1;
              wvalid_reg  <= 1'b1;
            end else begin
              state_reg   <= e_raddr;
              arvalid_reg <= 1'b1;
            end
          end
        end

        e_waddr: begin
          if (awvalid_reg & m_axil_awready_i) awvalid_reg <= 1'b0;
          if (wvalid_reg & m_axil_wready_i)   wvalid_reg  <= 1'b0;
          if (aw_done & w_done) begin
            state_reg  <= e_wresp;
            bready_reg <= 1'b1;
`ifdef BSG_AXIL_MASTER_TIMEOUT_EN
            timer_reg  <= '0;
`endif
          end
        end

        e_wresp: begin
          if (m_axil_bvalid_i) begin
            state_reg  <= e_resp;
            bready_reg <= 1'b0;
            resp_reg   <= m_axil_bresp_i;
            data_o_reg <= '0;
            w_o_reg    <= 1'b1;
            v_reg      <= 1'b1;
          end
`ifdef BSG_AXIL_MASTER_TIMEOUT_EN
          else if (timer_reg == timer_last_lp) begin
            state_reg     <= e_resp;
            bready_reg    <= 1'b0;
            resp_reg      <= 2'b11;
            data_o_reg    <= '0;
            w_o_reg       <= 1'b1;
            v_reg         <= 1'b1;
            timed_out_reg <= 1'b1;
          end else begin
            timer_reg <= timer_reg + timer_width_lp'(1);
          end
`endif
        end

        e_raddr: begin
          if (m_axil_arready_i) begin
            state_reg   <= e_rdata;
            arvalid_reg <= 1'b0;
            rready_reg  <= 1'b1;
`ifdef BSG_AXIL_MASTER_TIMEOUT_EN
            timer_reg   <= '0;
`endif
          end
        end

        e_rdata: begin
          if (m_axil_rvalid_i) begin
            state_reg  <= e_resp;
            rready_reg <= 1'b0;
            resp_reg   <= m_axil_rresp_i;
            data_o_reg <= m_axil_rdata_i;
            w_o_reg    <= 1'b0;
            v_reg      <= 1'b1;
          end
`ifdef BSG_AXIL_MASTER_TIMEOUT_EN
          else if (timer_reg == timer_last_lp) begin
            state_reg     <= e_resp;
            rready_reg    <= 1'b0;
            resp_reg      <= 2'b11;
            data_o_reg    <= '0;
            w_o_reg       <= 1'b0;
            v_reg         <= 1'b1;
            timed_out_reg <= 1'b1;
          end else begin
            timer_reg <= timer_reg + timer_width_lp'(1);
          end
`endif
        end

        e_resp: begin
          if (yumi_i) begin
            v_reg <= 1'b0;
`ifdef BSG_AXIL_MASTER_TIMEOUT_EN
            if (timed_out_reg) begin
              // A late response is still owed by the responder; swallow it
              // before taking new work.
              state_reg     <= e_drain;
              timed_out_reg <= 1'b0;
              bready_reg    <= w_reg;
              rready_reg    <= ~w_reg;
            end else begin
              state_reg <= e_idle;
              ready_reg <= 1'b1;
            end
`else
            state_reg <= e_idle;
            ready_reg <= 1'b1;
`endif
          end
        end

`ifdef BSG_AXIL_MASTER_TIMEOUT_EN
        e_drain: begin
          if ((w_reg & m_axil_bvalid_i) | (~w_reg & m_axil_rvalid_i)) begin
            state_reg  <= e_idle;
            bready_reg <= 1'b0;
            rready_reg <= 1'b0;
            ready_reg  <= 1'b1;
          end
        end
`endif

        default: begin
          state_reg <= e_idle;
          ready_reg <= 1'b1;
        end
      endcase
    end
  end

  assign ready_and_o      = ready_reg & ~reset_i;
  assign v_o              = v_reg;
  assign w_o              = w_o_reg;
  assign data_o           = data_o_reg;
  assign resp_o           = resp_reg;

  assign m_axil_awaddr_o  = addr_reg;
  assign m_axil_awprot_o  = 3'b000;
  assign m_axil_awvalid_o = awvalid_reg;
  assign m_axil_wdata_o   = data_reg;
  assign m_axil_wstrb_o   = wmask_reg;
  assign m_axil_wvalid_o  = wvalid_reg;
  assign m_axil_bready_o  = bready_reg;
  assign m_axil_araddr_o  = addr_reg;
  assign m_axil_arprot_o  = 3'b000;
  assign m_axil_arvalid_o = arvalid_reg;
  assign m_axil_rready_o  = rready_reg;

endmodule

// File: tb/tb_bsg_axil_master_fsm.sv
// tb_bsg_axil_master_fsm
// Directed and random single-beat transactions against an in-bench
// AXI-Lite responder. Expected results come from a byte-masked memory model
// that is indexed by the request inputs. Expected latency is computed from
// the handshake delays.
module tb_bsg_axil_master_fsm;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic          v_i, ready_and_o, w_i;
  logic [AW-1:0] addr_i;
  logic [DW-1:0] data_i;
  logic [SW-1:0] wmask_i;
  logic          v_o, yumi_i, w_o;
  logic [DW-1:0] data_o;
  logic [1:0]    resp_o;
  logic [AW-1:0] awaddr, araddr;
  logic [2:0]    awprot, arprot;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rvalid, rready;
  logic [DW-1:0] wdata, rdata;
  logic [SW-1:0] wstrb;
  logic [1:0]    bresp, rresp;

  int compared = 0;
  int mismatched = 0;
  int txn_id = 0;

  logic [DW-1:0] model_mem [logic [AW-1:0]];
  logic [DW-1:0] axi_mem   [logic [AW-1:0]];

  always #5 clk_i = ~clk_i;

  bsg_axil_master_fsm #(.addr_width_p(AW), .data_width_p(DW), .timeout_p(8)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .v_i(v_i), .ready_and_o(ready_and_o), .w_i(w_i), .addr_i(addr_i),
    .data_i(data_i), .wmask_i(wmask_i),
    .v_o(v_o), .yumi_i(yumi_i), .w_o(w_o), .data_o(data_o), .resp_o(resp_o),
    .m_axil_awaddr_o(awaddr), .m_axil_awprot_o(awprot), .m_axil_awvalid_o(awvalid),
    .m_axil_awready_i(awready),
    .m_axil_wdata_o(wdata), .m_axil_wstrb_o(wstrb), .m_axil_wvalid_o(wvalid),
    .m_axil_wready_i(wready),
    .m_axil_bresp_i(bresp), .m_axil_bvalid_i(bvalid), .m_axil_bready_o(bready),
    .m_axil_araddr_o(araddr), .m_axil_arprot_o(arprot), .m_axil_arvalid_o(arvalid),
    .m_axil_arready_i(arready),
    .m_axil_rdata_i(rdata), .m_axil_rresp_i(rresp), .m_axil_rvalid_i(rvalid),
    .m_axil_rready_o(rready)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                          input logic [SW-1:0] m);
    logic [DW-1:0] r;
    r = old;
    for (int i = 0; i < SW; i++) if (m[i]) r[i*8 +: 8] = d[i*8 +: 8];
    return r;
  endfunction

  // One full transaction: accept, responder with given stalls, response hold, yumi.
  task automatic run_txn(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [SW-1:0] m, input int adly, input int wdly,
                         input int rdly, input int ydly, input logic [1:0] rsp,
                         input bit hold_v);
    int c, exp_v, both_c, rr_c;
    bit aw_done, w_done, ar_done, resp_done;
    logic [AW-1:0] aw_cap, ar_cap;
    logic [DW-1:0] w_cap, exp_data;
    logic [SW-1:0] s_cap;

    chk("accept_ready", ready_and_o, 1);
    v_i = 1; w_i = w; addr_i = a; data_i = d; wmask_i = m;
    tick();
    if (!hold_v) v_i = 0;
    c = 1; both_c = -1; rr_c = -1;
    aw_done = 0; w_done = 0; ar_done = 0; resp_done = 0;
    aw_cap = '0; ar_cap = '0; w_cap = '0; s_cap = '0;
    exp_v = w ? (3 + ((adly > wdly) ? adly : wdly) + rdly) : (3 + adly + rdly);
    while (!resp_done && c < 300) begin
      chk("busy_ready", ready_and_o, 0);
      chk("busy_v", v_o, 0);
      chk("prot", {awprot, arprot}, 0);
      if (w) begin
        if (aw_done && w_done && both_c < 0) both_c = c;
        chk("awvalid", awvalid, !aw_done);
        chk("wvalid", wvalid, !w_done);
        chk("bready", bready, both_c >= 0);
        chk("w_arvalid_rready", {arvalid, rready}, 0);
        awready = !aw_done && (c >= 1 + adly);
        wready  = !w_done && (c >= 1 + wdly);
        bvalid  = (both_c >= 0) && (c >= both_c + rdly);
        bresp   = bvalid ? rsp : 2'b00;
        if (awvalid && awready) begin
          chk("awaddr", awaddr, a);
          aw_cap = awaddr; aw_done = 1;
        end
        if (wvalid && wready) begin
          chk("wdata", wdata, d);
          chk("wstrb", wstrb, m);
          w_cap = wdata; s_cap = wstrb; w_done = 1;
        end
        if (bvalid && bready) begin
          axi_mem[aw_cap] = merge(axi_mem.exists(aw_cap) ? axi_mem[aw_cap] : '0, w_cap, s_cap);
          resp_done = 1;
        end
      end else begin
        if (ar_done && rr_c < 0) rr_c = c;
        chk("arvalid", arvalid, !ar_done);
        chk("rready", rready, rr_c >= 0);
        chk("r_wchan", {awvalid, wvalid, bready}, 0);
        arready = !ar_done && (c >= 1 + adly);
        rvalid  = (rr_c >= 0) && (c >= rr_c + rdly);
        rresp   = rvalid ? rsp : 2'b00;
        rdata   = (rvalid && axi_mem.exists(ar_cap)) ? axi_mem[ar_cap] : '0;
        if (arvalid && arready) begin
          chk("araddr", araddr, a);
          ar_cap = araddr; ar_done = 1;
        end
        if (rvalid && rready) resp_done = 1;
      end
      tick();
      c++;
    end
    awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
    bresp = 0; rresp = 0; rdata = 0;
    chk("resp_in_budget", resp_done, 1);
    chk("latency", c, exp_v);

    if (w) begin
      model_mem[a] = merge(model_mem.exists(a) ? model_mem[a] : '0, d, m);
      exp_data = '0;
    end else begin
      exp_data = model_mem.exists(a) ? model_mem[a] : '0;
    end
    for (int k = 0; k <= ydly; k++) begin
      chk("resp_v", v_o, 1);
      chk("resp_data", data_o, exp_data);
      chk("resp_code", resp_o, rsp);
      chk("resp_w", w_o, w);
      chk("resp_ready", {ready_and_o, bready, rready}, 0);
      yumi_i = (k == ydly);
      tick();
    end
    yumi_i = 0;
    chk("post_v", v_o, 0);
    chk("post_ready", ready_and_o, 1);
    $display("txn %0d %s addr=%h data=%h mask=%h resp=%b latency=%0d",
             txn_id, w ? "WR" : "RD", a, w ? d : exp_data, m, rsp, c);
    txn_id++;
  endtask

  logic [1:0] rsp_tab [3] = '{2'b00, 2'b10, 2'b11};

  initial begin
    reset_i = 1; v_i = 0; w_i = 0; addr_i = '0; data_i = '0; wmask_i = '0; yumi_i = 0;
    awready = 0; wready = 0; bresp = 0; bvalid = 0; arready = 0;
    rdata = 0; rresp = 0; rvalid = 0;
    repeat (3) tick();

    // reset state
    chk("rst_ready", ready_and_o, 0);
    chk("rst_valids", {awvalid, wvalid, arvalid, bready, rready, v_o}, 0);
    chk("rst_resp", {data_o, resp_o, w_o}, 0);
    chk("rst_axi", {awaddr, wdata, wstrb}, 0);
    chk("rst_araddr", araddr, 0);
    reset_i = 0;
    #1;
    chk("rel_ready", ready_and_o, 1);
    tick();

    // directed: immediate write, minimum latency
    run_txn(1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 2'b00, 0);
    // directed: wready five cycles before awready
    run_txn(1, 32'h14, 32'h12345678, 4'h5, 5, 0, 1, 1, 2'b00, 0);
    // directed: read with 4 stall cycles, SLVERR, yumi held off 3 cycles
    axi_mem[32'h20]   = 32'hCAFEF00D;
    model_mem[32'h20] = 32'hCAFEF00D;
    run_txn(0, 32'h20, 32'h0, 4'h0, 0, 0, 4, 3, 2'b10, 0);
    // directed: immediate read of the earlier write
    run_txn(0, 32'h10, 32'h0, 4'h0, 0, 0, 0, 0, 2'b00, 0);
    // directed: v_i held across two requests, yumi delayed 3 cycles
    run_txn(1, 32'h18, 32'hA5A5A5A5, 4'hF, 0, 0, 0, 3, 2'b00, 1);
    run_txn(1, 32'h18, 32'hA5A5A5A5, 4'hF, 0, 0, 0, 3, 2'b11, 0);

    // directed: reset while waiting in WRESP
    v_i = 1; w_i = 1; addr_i = 32'h30; data_i = 32'h11112222; wmask_i = 4'hF;
    tick();
    v_i = 0; awready = 1; wready = 1;
    tick();
    awready = 0; wready = 0;
    chk("wresp_bready", bready, 1);
    reset_i = 1;
    tick();
    chk("midrst_valids", {awvalid, wvalid, arvalid, bready, rready, v_o, ready_and_o}, 0);
    reset_i = 0;
    #1;
    chk("midrst_rel_ready", ready_and_o, 1);
    tick();
    chk("midrst_idle", {ready_and_o, awvalid, bready}, 3'b100);
    $display("txn %0d RST during WRESP", txn_id);
    txn_id++;

    // random traffic against the memory model
    for (int n = 0; n < 40; n++) begin
      run_txn(1'($urandom_range(0, 1)), AW'($urandom_range(0, 7) * 4), $urandom,
              SW'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 4), $urandom_range(0, 2), rsp_tab[$urandom_range(0, 2)], 0);
    end

`ifdef BSG_AXIL_MASTER_TIMEOUT_EN
    // timeout: read with no rvalid, then a late response drained
    v_i = 1; w_i = 0; addr_i = 32'h44;
    tick();
    v_i = 0; arready = 1;
    tick();
    arready = 0;
    for (int k = 0; k < 8; k++) begin
      chk("to_rready", rready, 1);
      chk("to_wait_v", v_o, 0);
      tick();
    end
    chk("to_v", v_o, 1);
    chk("to_resp", resp_o, 2'b11);
    chk("to_data_w", {data_o, w_o}, 0);
    chk("to_ready", {ready_and_o, rready}, 0);
    yumi_i = 1;
    tick();
    yumi_i = 0;
    for (int k = 0; k < 3; k++) begin
      chk("drain_ready", ready_and_o, 0);
      chk("drain_rready", rready, 1);
      tick();
    end
    rvalid = 1; rdata = $urandom;
    chk("drain_last_ready", ready_and_o, 0);
    tick();
    rvalid = 0; rdata = 0;
    chk("drain_done", {ready_and_o, rready, v_o}, 3'b100);
    $display("txn %0d RD timeout+drain", txn_id);
    txn_id++;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
